// File: rtl/wavetable_recorder.sv
`default_nettype none
// ============================================================================
//  Module   : wavetable_recorder
//  Purpose  : Capture side of the audio path. Generates the PDM microphone
//             clock, decimates the 1-bit microphone stream into SAMPLE_W-bit
//             samples by ones-counting over DECIM bits, and fills one
//             DEPTH-entry wavetable per Record request. The table is read
//             through a registered port (1-cycle latency).
//  Ports    : CLK      - system clock
//             RESET    - asynchronous reset, active-high
//             Record   - level request, rising edge starts a capture
//             Mic_In   - PDM data from the microphone
//             MIC_CLK  - microphone clock, CLK/(2*MIC_CLK_DIV)
//             RD_ADDR  - table read address
//             RD_DATA  - table read data, registered
//             BUSY     - high while a capture (or arm phase) is in progress
//             DONE     - one-cycle pulse when the table is complete
//  Options  : WTREC_TRIGGER_EN - when defined, a capture first waits in an
//             ARM state until a sample deviates from midscale by more than
//             TRIG_LEVEL; that sample becomes entry 0.
//  Revision : 1.0 - initial release
// ============================================================================
module wavetable_recorder #(
    parameter int DEPTH       = 32,
    parameter int SAMPLE_W    = 8,
    parameter int DECIM       = 256,
    parameter int MIC_CLK_DIV = 40,
    parameter int TRIG_LEVEL  = 32
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     Record,
    input  logic                     Mic_In,
    output logic                     MIC_CLK,
    input  logic [$clog2(DEPTH)-1:0] RD_ADDR,
    output logic [SAMPLE_W-1:0]      RD_DATA,
    output logic                     BUSY,
    output logic                     DONE
);

    localparam int C_ADDR_W = $clog2(DEPTH);
    localparam int C_LOG_D  = $clog2(DECIM);
    localparam int C_ONES_W = C_LOG_D + 1;
    localparam int C_SHIFT  = C_LOG_D - SAMPLE_W;
    localparam int C_DIV_W  = $clog2(MIC_CLK_DIV);

    localparam logic [C_DIV_W-1:0]  C_DIV_LAST = C_DIV_W'(MIC_CLK_DIV - 1);
    localparam logic [SAMPLE_W-1:0] C_MID      = SAMPLE_W'(2 ** (SAMPLE_W - 1));
    localparam logic [SAMPLE_W-1:0] C_SAT      = {SAMPLE_W{1'b1}};
    localparam logic [C_ONES_W-1:0] C_SAT_CMP  = C_ONES_W'(2 ** SAMPLE_W - 1);

    localparam logic [1:0] C_IDLE    = 2'd0;
    localparam logic [1:0] C_ARM     = 2'd1;
    localparam logic [1:0] C_CAPTURE = 2'd2;
    localparam logic [1:0] C_FINISH  = 2'd3;

`ifdef WTREC_TRIGGER_EN
    localparam logic [1:0] C_START = C_ARM;
`else
    localparam logic [1:0] C_START = C_CAPTURE;
`endif

    // ------------------------------------------------------------------
    // Microphone clock divider (free-running in every state)
    // ------------------------------------------------------------------
    logic [C_DIV_W-1:0] r_div_cnt;
    logic               r_mic_clk;
    logic               w_div_wrap;
    logic               w_tick;

    assign w_div_wrap = (r_div_cnt == C_DIV_LAST);
    // A tick is the cycle whose edge takes MIC_CLK from 1 to 0; the
    // microphone data is taken on that same edge.
    assign w_tick     = w_div_wrap & r_mic_clk;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_div_cnt <= '0;
            r_mic_clk <= 1'b0;
        end else if (w_div_wrap) begin
            r_div_cnt <= '0;
            r_mic_clk <= ~r_mic_clk;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Record synchroniser and rising-edge detect
    // ------------------------------------------------------------------
    logic r_rec_meta;
    logic r_rec_sync;
    logic r_rec_prev;
    logic w_rec_rise;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_rec_meta <= 1'b0;
            r_rec_sync <= 1'b0;
            r_rec_prev <= 1'b0;
        end else begin
            r_rec_meta <= Record;
            r_rec_sync <= r_rec_meta;
            r_rec_prev <= r_rec_sync;
        end
    end

    assign w_rec_rise = r_rec_sync & ~r_rec_prev;

    // ------------------------------------------------------------------
    // Decimator datapath
    // ------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [C_ONES_W-1:0] r_ones_cnt;
    logic [C_LOG_D-1:0]  r_bit_cnt;
    logic [C_ADDR_W-1:0] r_wr_ptr;

    logic [C_ONES_W-1:0] w_ones_next;
    logic [C_ONES_W-1:0] w_shifted;
    logic [SAMPLE_W-1:0] w_sample;
    logic [SAMPLE_W-1:0] w_dev;
    logic                w_bit_wrap;
    logic                w_trig_hit;
    logic                w_wr_en;

    // Include the bit arriving on this tick so the final bit of a window
    // lands in the sample written on the same edge.
    assign w_ones_next = r_ones_cnt + {{C_LOG_D{1'b0}}, Mic_In};
    assign w_shifted   = w_ones_next >> C_SHIFT;
    // DECIM ones would overflow the sample width by one; clamp to full scale.
    assign w_sample    = (w_shifted > C_SAT_CMP) ? C_SAT : w_shifted[SAMPLE_W-1:0];
    assign w_bit_wrap  = &r_bit_cnt;

    assign w_dev       = (w_sample >= C_MID) ? (w_sample - C_MID) : (C_MID - w_sample);
    assign w_trig_hit  = (int'(w_dev) > TRIG_LEVEL);

    // ARM is unreachable unless the trigger option selects it as the start
    // state, so the trigger term drops out of the default build.
    assign w_wr_en = w_tick & w_bit_wrap &
                     ((r_state == C_CAPTURE) | ((r_state == C_ARM) & w_trig_hit));

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state    <= C_IDLE;
            r_ones_cnt <= '0;
            r_bit_cnt  <= '0;
            r_wr_ptr   <= '0;
        end else begin
            case (r_state)
                C_IDLE: begin
                    r_ones_cnt <= '0;
                    r_bit_cnt  <= '0;
                    r_wr_ptr   <= '0;
                    if (w_rec_rise) begin
                        r_state <= C_START;
                    end
                end
                C_ARM, C_CAPTURE: begin
                    if (w_tick) begin
                        r_bit_cnt  <= r_bit_cnt + 1'b1;
                        r_ones_cnt <= w_bit_wrap ? '0 : w_ones_next;
                    end
                    if (w_wr_en) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        if (r_state == C_ARM) begin
                            r_state <= C_CAPTURE;
                        end else if (&r_wr_ptr) begin
                            r_state <= C_FINISH;
                        end
                    end
                end
                C_FINISH: begin
                    r_wr_ptr <= '0;
                    r_state  <= C_IDLE;
                end
                default: begin
                    r_state <= C_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Wavetable RAM: not touched by RESET; loads midscale at configuration
    // so an unrecorded table plays silence.
    // ------------------------------------------------------------------
    logic [SAMPLE_W-1:0] r_mem [DEPTH] = '{default: C_MID};

    always_ff @(posedge CLK) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_sample;
        end
    end

    // Read-before-write: a same-cycle read of the written address sees old data.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            RD_DATA <= '0;
        end else begin
            RD_DATA <= r_mem[RD_ADDR];
        end
    end

    assign MIC_CLK = r_mic_clk;
    assign BUSY    = (r_state != C_IDLE);
    assign DONE    = (r_state == C_FINISH);

endmodule
`default_nettype wire

// File: tb/tb_wavetable_recorder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wavetable_recorder
//  Purpose  : Directed self-checking bench for wavetable_recorder. Uses a
//             reduced table (8 entries) and a fast microphone clock so that
//             several complete captures fit in a short run; sample width and
//             decimation keep their full values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wavetable_recorder;

    localparam int DEPTH = 8;
    localparam int SW    = 8;
    localparam int DECIM = 256;
    localparam int DIV   = 2;
    localparam int TRIG  = 64;
    localparam int AW    = $clog2(DEPTH);
    // Busy length of a full capture: up to one tick period to the first tick,
    // then DEPTH*DECIM ticks of 2*DIV cycles, then one FINISH cycle.
    localparam int FULL_MIN = (DEPTH * DECIM - 1) * 2 * DIV + 2;
    localparam int FULL_MAX = (DEPTH * DECIM - 1) * 2 * DIV + 2 * DIV + 4;

    logic          CLK;
    logic          RESET;
    logic          Record;
    logic          Mic_In;
    logic          MIC_CLK;
    logic [AW-1:0] RD_ADDR;
    logic [SW-1:0] RD_DATA;
    logic          BUSY;
    logic          DONE;

    wavetable_recorder #(
        .DEPTH      (DEPTH),
        .SAMPLE_W   (SW),
        .DECIM      (DECIM),
        .MIC_CLK_DIV(DIV),
        .TRIG_LEVEL (TRIG)
    ) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .Record (Record),
        .Mic_In (Mic_In),
        .MIC_CLK(MIC_CLK),
        .RD_ADDR(RD_ADDR),
        .RD_DATA(RD_DATA),
        .BUSY   (BUSY),
        .DONE   (DONE)
    );

    int checks;
    int errors;
    int mic_mode;
    int tick_n;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Microphone model: after every falling MIC_CLK edge present the bit for
    // the next tick. 0: zeros, 1: ones, 2: alternating, 3: three of four ones.
    initial begin
        Mic_In = 1'b0;
        tick_n = 0;
        forever begin
            @(negedge MIC_CLK);
            tick_n = tick_n + 1;
            #1;
            case (mic_mode)
                0:       Mic_In = 1'b0;
                1:       Mic_In = 1'b1;
                2:       Mic_In = ((tick_n % 2) != 0);
                default: Mic_In = ((tick_n % 4) != 0);
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic read_entry(input int a, output logic [SW-1:0] d);
        logic [31:0] av;
        av = a;
        @(negedge CLK);
        RD_ADDR = av[AW-1:0];
        @(negedge CLK);
        d = RD_DATA;
    endtask

    task automatic wait_busy(input logic lvl, input int max, input string tag);
        int n;
        n = 0;
        while (BUSY !== lvl && n < max) begin
            @(negedge CLK);
            n = n + 1;
        end
        chk(tag, {31'd0, BUSY}, {31'd0, lvl});
    endtask

    task automatic run_to_idle(output int len, output int dones);
        len   = 0;
        dones = 0;
        while (BUSY === 1'b1 && len < 30000) begin
            @(negedge CLK);
            len = len + 1;
            if (DONE === 1'b1) dones = dones + 1;
        end
    endtask

    task automatic check_table(input logic [SW-1:0] exp, input string tag);
        logic [SW-1:0] d;
        for (int i = 0; i < DEPTH; i++) begin
            read_entry(i, d);
            chk($sformatf("%s_e%0d", tag, i), {24'd0, d}, {24'd0, exp});
        end
    endtask

    task automatic start_capture(input string tag);
        @(negedge CLK);
        Record = 1'b1;
        wait_busy(1'b1, 20, {tag, "_busy_rise"});
        Record = 1'b0;
    endtask

    task automatic full_capture(input int mode, input logic [SW-1:0] exp, input string tag);
        int len;
        int dn;
        mic_mode = mode;
        repeat (8) @(negedge CLK);
        start_capture(tag);
        run_to_idle(len, dn);
        chk({tag, "_idle"}, {31'd0, BUSY}, 32'd0);
        chk({tag, "_done_pulses"}, dn, 1);
        chk({tag, "_len_in_range"}, {31'd0, (len >= FULL_MIN && len <= FULL_MAX)}, 32'd1);
        check_table(exp, tag);
    endtask

    logic [SW-1:0] d;
    int prevm;
    int r1;
    int r2;
    int len;
    int dn;
    int start;
    int n;
    int busy_seen;

    initial begin
        checks   = 0;
        errors   = 0;
        mic_mode = 0;
        RESET    = 1'b1;
        Record   = 1'b0;
        RD_ADDR  = AW'(5);
        repeat (3) @(negedge CLK);
        chk("rst_mic_clk", {31'd0, MIC_CLK}, 32'd0);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_done", {31'd0, DONE}, 32'd0);
        chk("rst_rd_data", {24'd0, RD_DATA}, 32'd0);
        RESET = 1'b0;

        read_entry(5, d);
        chk("powerup_midscale", {24'd0, d}, 32'd128);

        // MIC_CLK period: 2*DIV system clocks between rising edges.
        r1 = -1;
        r2 = -1;
        prevm = int'(MIC_CLK);
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (MIC_CLK === 1'b1 && prevm == 0) begin
                if (r1 < 0) r1 = i;
                else if (r2 < 0) r2 = i;
            end
            prevm = int'(MIC_CLK);
        end
        chk("mic_clk_period", r2 - r1, 2 * DIV);

`ifdef WTREC_TRIGGER_EN
        // Three 50% samples (128, within threshold) then all-ones: the first
        // all-ones sample triggers and becomes entry 0.
        mic_mode = 2;
        repeat (8) @(negedge CLK);
        start_capture("trig");
        start = tick_n;
        n = 0;
        while (tick_n < start + 3 * DECIM - 1 && n < 20000) begin
            @(negedge CLK);
            n = n + 1;
        end
        mic_mode = 1;
        run_to_idle(len, dn);
        chk("trig_idle", {31'd0, BUSY}, 32'd0);
        chk("trig_done_pulses", dn, 1);
        len = len + n;
        chk("trig_len_in_range",
            {31'd0, (len >= FULL_MIN + 3 * DECIM * 2 * DIV && len <= FULL_MAX + 3 * DECIM * 2 * DIV)},
            32'd1);
        check_table(8'd255, "trig");
`else
        full_capture(1, 8'd255, "ones");
        full_capture(2, 8'd128, "alt");
        full_capture(3, 8'd192, "three_q");

        // Record held high through DONE: no second capture.
        mic_mode = 1;
        repeat (8) @(negedge CLK);
        @(negedge CLK);
        Record = 1'b1;
        wait_busy(1'b1, 20, "hold_busy_rise");
        run_to_idle(len, dn);
        chk("hold_done_pulses", dn, 1);
        busy_seen = 0;
        repeat (50) begin
            @(negedge CLK);
            if (BUSY !== 1'b0) busy_seen = 1;
        end
        chk("hold_no_restart", busy_seen, 0);
        read_entry(0, d);
        chk("hold_e0", {24'd0, d}, 32'd255);
        read_entry(DEPTH - 1, d);
        chk("hold_elast", {24'd0, d}, 32'd255);

        // Drop and raise: new capture; a second edge mid-capture is ignored.
        mic_mode = 0;
        Record = 1'b0;
        repeat (8) @(negedge CLK);
        start_capture("rearm");
        repeat (100) @(negedge CLK);
        Record = 1'b0;
        repeat (5) @(negedge CLK);
        Record = 1'b1;
        run_to_idle(len, dn);
        len = len + 105;
        chk("rearm_done_pulses", dn, 1);
        chk("rearm_len_in_range", {31'd0, (len >= FULL_MIN && len <= FULL_MAX)}, 32'd1);
        busy_seen = 0;
        repeat (50) begin
            @(negedge CLK);
            if (BUSY !== 1'b0) busy_seen = 1;
        end
        chk("rearm_no_restart", busy_seen, 0);
        Record = 1'b0;
        check_table(8'd0, "zeros");

        // RESET midway through entry 4: entries 0..3 new, the rest old.
        mic_mode = 1;
        repeat (8) @(negedge CLK);
        start_capture("abort");
        start = tick_n;
        n = 0;
        dn = 0;
        while (tick_n < start + 4 * DECIM + DECIM / 2 && n < 20000) begin
            @(negedge CLK);
            n = n + 1;
            if (DONE === 1'b1) dn = dn + 1;
        end
        #2 RESET = 1'b1;
        #1;
        chk("abort_busy", {31'd0, BUSY}, 32'd0);
        chk("abort_done", {31'd0, DONE}, 32'd0);
        chk("abort_mic_clk", {31'd0, MIC_CLK}, 32'd0);
        chk("abort_no_done_before", dn, 0);
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        busy_seen = 0;
        repeat (20) begin
            @(negedge CLK);
            if (BUSY !== 1'b0 || DONE !== 1'b0) busy_seen = 1;
        end
        chk("abort_stays_idle", busy_seen, 0);
        for (int i = 0; i < DEPTH; i++) begin
            read_entry(i, d);
            chk($sformatf("abort_e%0d", i), {24'd0, d}, (i < 4) ? 32'd255 : 32'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
